// File: rtl/debouncer_multi_pkg.sv
// rtl/debouncer_multi_pkg.sv - shared sizing helpers for the multi-lane debouncer
package debouncer_multi_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounce lane: synchronizer, settle counter, level, valid and edge pulses
module debounce_channel
    import debouncer_multi_pkg::*;
#(
    parameter int   high_count  = 4,
    parameter int   low_count   = 4,
    parameter int   sync_stages = 2,
    parameter logic reset_value = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic in,
    output logic out,
    output logic valid,
    output logic rising_pulse,
    output logic falling_pulse
);

    localparam int max_count = max(high_count, low_count);
    localparam int cnt_w     = clog2(max_count + 1);
    localparam logic [cnt_w-1:0] high_load = cnt_w'(high_count);
    localparam logic [cnt_w-1:0] low_load  = cnt_w'(low_count);
    localparam logic [cnt_w-1:0] cnt_init  = cnt_w'(max_count);

    logic s;

    generate
        if (sync_stages == 0) begin : g_nosync
            assign s = in;
        end else begin : g_sync
            logic [sync_stages-1:0] sync_q;
            logic [sync_stages-1:0] sync_d;

            always_comb begin
                sync_d = sync_stages'({sync_q, in});
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync_q <= {sync_stages{reset_value}};
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s = sync_q[sync_stages-1];
        end
    endgenerate

    logic             s_prev_q, s_prev_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             settled;

    // A change reloads the count even while enable is low, so glitches never accumulate.
    always_comb begin
        settled  = (cnt_q == '0);
        s_prev_d = s;
        cnt_d    = cnt_q;
        if (s != s_prev_q) begin
            cnt_d = s ? high_load : low_load;
        end else if (enable && !settled) begin
            cnt_d = cnt_q - cnt_w'(1);
        end
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (settled && (out_q != s_prev_q)) begin
            out_d  = s_prev_q;
            rise_d = s_prev_q;
            fall_d = !s_prev_q;
        end
        valid_d = settled;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_prev_q <= reset_value;
            cnt_q    <= cnt_init;
            out_q    <= reset_value;
            valid_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s_prev_q <= s_prev_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign out           = out_q;
    assign valid         = valid_q;
    assign rising_pulse  = rise_q;
    assign falling_pulse = fall_q;

endmodule

// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - independent debounce lanes plus a round-robin settled-edge event queue
module debouncer_multi
    import debouncer_multi_pkg::*;
#(
    parameter int                  channels    = 4,
    parameter int                  high_count  = 4,
    parameter int                  low_count   = 4,
    parameter int                  sync_stages = 2,
    parameter logic [channels-1:0] reset_value = '0,
    localparam int                 ch_w        = max(1, clog2(channels))
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [channels-1:0] in,
    output logic [channels-1:0] out,
    output logic [channels-1:0] valid,
    output logic [channels-1:0] rising_pulse,
    output logic [channels-1:0] falling_pulse,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [ch_w-1:0]     event_channel,
    output logic                event_rising,
    output logic                event_dropped
);

    generate
        for (genvar g = 0; g < channels; g++) begin : g_lane
            debounce_channel #(
                .high_count  (high_count),
                .low_count   (low_count),
                .sync_stages (sync_stages),
                .reset_value (reset_value[g])
            ) u_lane (
                .clock         (clock),
                .reset         (reset),
                .enable        (enable),
                .in            (in[g]),
                .out           (out[g]),
                .valid         (valid[g]),
                .rising_pulse  (rising_pulse[g]),
                .falling_pulse (falling_pulse[g])
            );
        end
    endgenerate

    logic [channels-1:0] pending_q, pending_d;
    logic [channels-1:0] dir_q, dir_d;
    logic [ch_w-1:0]     ptr_q, ptr_d;
    logic                event_valid_q, event_valid_d;
    logic [ch_w-1:0]     event_channel_q, event_channel_d;
    logic                event_rising_q, event_rising_d;
    logic                event_dropped_q, event_dropped_d;

    logic [channels-1:0] pulse;
    logic [channels-1:0] req;
    logic [channels-1:0] grant_oh;
    logic [ch_w-1:0]     grant_idx;
    logic [ch_w-1:0]     sel;
    logic                grant_dir;
    logic                found;
    logic                load;

    // Fresh pulses join the request vector directly so an idle queue reports an edge one cycle later.
    always_comb begin
        pulse     = rising_pulse | falling_pulse;
        req       = pending_q | pulse;
        load      = !event_valid_q || event_ready;
        found     = 1'b0;
        grant_idx = '0;
        sel       = '0;
        grant_oh  = '0;
        for (int i = 1; i <= channels; i++) begin
            sel = ch_w'((int'(ptr_q) + i) % channels);
            if (!found && req[sel]) begin
                found     = 1'b1;
                grant_idx = sel;
            end
        end
        if (load && found) begin
            grant_oh[grant_idx] = 1'b1;
        end
        grant_dir = pending_q[grant_idx] ? dir_q[grant_idx] : rising_pulse[grant_idx];

        pending_d       = pending_q;
        dir_d           = dir_q;
        event_dropped_d = 1'b0;
        for (int j = 0; j < channels; j++) begin
            if (grant_oh[j]) begin
                pending_d[j] = 1'b0;
            end
            // A pulse granted straight through needs no slot; otherwise it occupies one.
            if (pulse[j] && !(grant_oh[j] && !pending_q[j])) begin
                if (pending_q[j] && !grant_oh[j]) begin
                    event_dropped_d = 1'b1;
                end
                pending_d[j] = 1'b1;
                dir_d[j]     = rising_pulse[j];
            end
        end

        ptr_d           = ptr_q;
        event_valid_d   = event_valid_q;
        event_channel_d = event_channel_q;
        event_rising_d  = event_rising_q;
        if (load) begin
            event_valid_d = found;
            if (found) begin
                event_channel_d = grant_idx;
                event_rising_d  = grant_dir;
                ptr_d           = grant_idx;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q       <= '0;
            dir_q           <= '0;
            ptr_q           <= ch_w'(channels - 1);
            event_valid_q   <= 1'b0;
            event_channel_q <= '0;
            event_rising_q  <= 1'b0;
            event_dropped_q <= 1'b0;
        end else begin
            pending_q       <= pending_d;
            dir_q           <= dir_d;
            ptr_q           <= ptr_d;
            event_valid_q   <= event_valid_d;
            event_channel_q <= event_channel_d;
            event_rising_q  <= event_rising_d;
            event_dropped_q <= event_dropped_d;
        end
    end

    assign event_valid   = event_valid_q;
    assign event_channel = event_channel_q;
    assign event_rising  = event_rising_q;
    assign event_dropped = event_dropped_q;

endmodule
